// File: rtl/llr_seq_addsub_if.sv
// Request/result handshake bundle for llr_seq_addsub: operands and mode in, result and flags out.
interface llr_seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, carry, overflow, acc
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, carry, overflow, acc
  );
endinterface

// File: rtl/llr_seq_addsub.sv
// Chunked sequential add/sub/accumulate with signed-overflow flag; CHUNK bits resolved per cycle.
// Optional result clamping on signed overflow when LLR_SEQ_SATURATE_EN is defined.
module llr_seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  llr_seq_addsub_if.slave bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("llr_seq_addsub: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               carry_r;
  logic               ovf_r;
  logic [WIDTH-1:0]   acc_r;

  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cy_r;
  logic [1:0]         mode_r;

  logic [WIDTH-1:0]   x_in;
  logic [WIDTH-1:0]   y_in;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   sum_nx;
  logic               ovf_nx;
  logic [WIDTH-1:0]   res_fin;
  logic               acc_upd;

  always_comb begin
    x_in = bus.op_a;
    y_in = bus.op_b;
    case (bus.mode)
      2'b01:   y_in = ~bus.op_b;
      2'b10: begin
        x_in = acc_r;
        y_in = bus.op_a;
      end
      2'b11: begin
        x_in = '0;
        y_in = bus.op_a;
      end
      default: ;
    endcase
  end

  // Stage: one chunk of the ripple add per CALC cycle, carry held in cy_r between chunks.
  always_comb begin
    int lo;
    lo        = CHUNK * int'(cnt);
    chunk_sum = {1'b0, x_r[lo +: CHUNK]} + {1'b0, y_r[lo +: CHUNK]} + (CHUNK+1)'(cy_r);
    sum_nx    = sum_r;
    sum_nx[lo +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  assign ovf_nx  = (x_r[MSB] == y_r[MSB]) && (sum_nx[MSB] != x_r[MSB]);
  assign acc_upd = (mode_r == 2'b10) || (mode_r == 2'b11);

`ifdef LLR_SEQ_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_fn(input logic [WIDTH-1:0] s,
                                              input logic ovf,
                                              input logic x_msb);
    if (!ovf) return s;
    return x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign res_fin = sat_fn(sum_nx, ovf_nx, x_r[MSB]);
`else
  assign res_fin = sum_nx;
`endif

  // Operand capture and chunk datapath; aborted work is simply discarded, so no reset here.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      x_r    <= x_in;
      y_r    <= y_in;
      cy_r   <= (bus.mode == 2'b01);
      mode_r <= bus.mode;
    end else if (state == CALC) begin
      sum_r  <= sum_nx;
      cy_r   <= chunk_sum[CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      acc_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= CALC;
            cnt        <= '0;
            in_ready_r <= 1'b0;
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            state       <= DONE;
            cnt         <= '0;
            out_valid_r <= 1'b1;
            result_r    <= res_fin;
            carry_r     <= chunk_sum[CHUNK];
            ovf_r       <= ovf_nx;
            if (acc_upd) acc_r <= res_fin;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = ovf_r;
  assign bus.acc       = acc_r;

endmodule

// File: tb/tb_llr_seq_addsub.sv
// Bench for llr_seq_addsub (WIDTH=8, CHUNK=4): directed plan items plus random ops vs an arithmetic model.
module tb_llr_seq_addsub;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] model_acc = '0;

  always #5 clk = ~clk;

  llr_seq_addsub_if #(.WIDTH(W)) bus ();

  llr_seq_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: true integer sum/difference, signed range test, optional clamp.
  task automatic model_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic c, output logic o);
    int ua, ub, uacc, sa, sb, sacc, full, tru;
    ua = int'(a); ub = int'(b); uacc = int'(model_acc);
    sa = $signed(a); sb = $signed(b); sacc = $signed(model_acc);
    case (m)
      2'b00:   begin full = ua + ub;           tru = sa + sb;   end
      2'b01:   begin full = ua + (255 - ub) + 1; tru = sa - sb; end
      2'b10:   begin full = uacc + ua;         tru = sacc + sa; end
      default: begin full = ua;                tru = sa;        end
    endcase
    r = full[7:0];
    c = full[8];
    o = (tru > 127) || (tru < -128);
`ifdef LLR_SEQ_SATURATE_EN
    if (o) r = (tru > 0) ? 8'h7F : 8'h80;
`endif
    if (m[1]) model_acc = r;
  endtask

  task automatic start_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    int waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("in_ready_before_req", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.op_a     = a;
    bus.op_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", bus.in_ready, 0);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      chk("ready_valid_exclusive", bus.in_ready & bus.out_valid, 0);
    end
    chk("latency", lat, LAT);
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs", bus.out_valid, 0);
    chk("in_ready_after_hs", bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic c, o;
    int lat;
    model_op(m, a, b, r, c, o);
    start_op(m, a, b);
    wait_result(lat);
    chk("result", bus.result, r);
    chk("carry", bus.carry, c);
    chk("overflow", bus.overflow, o);
    chk("acc", bus.acc, model_acc);
    handshake();
  endtask

  initial begin
    logic [W-1:0] r;
    logic c, o;
    int lat;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'b00;
    bus.op_a      = '0;
    bus.op_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_acc", bus.acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed plan items
    run_op(2'b00, 8'h7F, 8'h01);
`ifdef LLR_SEQ_SATURATE_EN
    chk("sat_pos_const", bus.result, 8'h7F);
`else
    chk("wrap_pos_const", bus.result, 8'h80);
`endif
    run_op(2'b01, 8'h05, 8'h07);
    chk("borrow_const", bus.result, 8'hFE);
    run_op(2'b01, 8'h07, 8'h05);
    chk("noborrow_carry", bus.carry, 1);
    run_op(2'b00, 8'hFF, 8'h01);
    chk("chain_const", bus.result, 8'h00);
    run_op(2'b00, 8'h80, 8'hFF);
    run_op(2'b11, 8'h10, 8'h00);
    chk("acc_load", bus.acc, 8'h10);
    run_op(2'b10, 8'h20, 8'h55);
    chk("acc_add1", bus.acc, 8'h30);
    run_op(2'b10, 8'h30, 8'hAA);
    chk("acc_add2", bus.acc, 8'h60);
    run_op(2'b00, 8'h12, 8'h34);
    chk("acc_kept", bus.acc, 8'h60);

    // Backpressure: result must hold and stray requests must be ignored
    model_op(2'b00, 8'h3C, 8'h11, r, c, o);
    start_op(2'b00, 8'h3C, 8'h11);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i % 2 == 0);
      bus.mode     = 2'b11;
      bus.op_a     = 8'($urandom);
      bus.op_b     = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", bus.result, r);
      chk("bp_carry", bus.carry, c);
      chk("bp_overflow", bus.overflow, o);
      chk("bp_acc", bus.acc, model_acc);
    end
    bus.in_valid = 1'b0;
    handshake();
    @(posedge clk); #1;
    chk("bp_no_capture", bus.out_valid, 0);
    run_op(2'b10, 8'h01, 8'h00);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end
    run_op(2'b11, 8'h55, 8'h00);

    // Asynchronous reset during CALC
    start_op(2'b00, 8'h7F, 8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_result", bus.result, 0);
    chk("arst_carry", bus.carry, 0);
    chk("arst_overflow", bus.overflow, 0);
    chk("arst_acc", bus.acc, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_out_valid", bus.out_valid, 0);
    model_acc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_acc", bus.acc, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("aborted_not_presented", bus.out_valid, 0);
    end
    run_op(2'b10, 8'h05, 8'h00);
    chk("acc_after_rst", bus.acc, 8'h05);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
